sha256_round_ctrl: RTL and testbench
====================================

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter: NUM_ROUNDS, default 64, rounds per block; legal range 2..64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset; synchronous, active-low.
REQ-004 block_valid  input  1  new 512-bit message block is presented.
REQ-005 block_first  input  1  presented block starts a new message; qualified by block_valid.
REQ-006 block_last  input  1  presented block ends the message; qualified by block_valid.
REQ-007 block_ready  output  1  controller accepts a block this cycle.
REQ-008 init_round  output  1  load A-H registers from the H source.
REQ-009 partial_rounds  output  1  apply one compression round.
REQ-010 init_digest  output  1  load H registers from initial or previous hash.
REQ-011 update_digest  output  1  add A-H into H.
REQ-012 first_block  output  1  selects initial hash constants as the H/A-H source.
REQ-013 round_idx  output  6  round number driving the K ROM and W schedule.
REQ-014 w_load  output  1  capture the accepted block into the W schedule.
REQ-015 busy  output  1  a block is in progress.
REQ-016 digest_valid  output  1  H registers hold the final message digest; one-cycle pulse.

Function
REQ-017 The FSM SHALL have states IDLE, INIT, ROUND, DIGEST and DONE; all outputs are registered or decoded from state only.
REQ-018 IDLE: block_ready=1. block_valid=1 SHALL cause acceptance, w_load=1 in that cycle, capture of block_last, and a move to INIT.
REQ-019 INIT lasts one cycle: init_round=1, init_digest=1, round_idx=0, then ROUND.
REQ-020 ROUND lasts NUM_ROUNDS cycles: partial_rounds=1, round_idx counts 0..NUM_ROUNDS-1 without skipping; at NUM_ROUNDS-1 the FSM moves to DIGEST.
REQ-021 DIGEST lasts one cycle: update_digest=1, round_idx=0. Then DONE if the captured last flag is set, else IDLE.
REQ-022 DONE lasts one cycle: digest_valid=1, then IDLE.
REQ-023 Timing for acceptance at cycle t: INIT at t+1, rounds at t+2..t+NUM_ROUNDS+1, DIGEST at t+NUM_ROUNDS+2, digest_valid at t+NUM_ROUNDS+3 for a last block.
REQ-024 A message-active flag SHALL be set on acceptance and cleared in DONE.
REQ-025 first_block SHALL be held from acceptance through DIGEST. Its value is 1 if block_first=1, or if no message is active; otherwise it is 0.
REQ-026 block_first=1 accepted while a message is active SHALL restart the message with the initial hash; no digest_valid is issued for the abandoned message.
REQ-027 block_valid outside IDLE SHALL be ignored (block_ready=0); the block is not lost and stays pending at the source.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Exactly one of init_round, partial_rounds and update_digest SHALL be high in any cycle, or none; the datapath never sees both case bits set.

Reset
REQ-030 reset_n=0 at a rising edge SHALL, from any state including mid-round, force IDLE, clear round_idx, the captured last flag and the message-active flag, and drive every output to 0 except block_ready.
REQ-031 block_ready SHALL be 0 during reset and 1 in the first cycle after reset_n rises.

Configuration
REQ-032 Macro SHA256_BLOCK_CNT_EN defined: the block SHALL add output block_count (16 bits), cleared on reset and on first_block acceptance, incremented at each DIGEST, and saturating at 16'hFFFF.
REQ-033 SHA256_BLOCK_CNT_EN undefined: port block_count and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 The shared package sha256_pkg SHALL hold the FSM state enum, the NUM_ROUNDS default and ROUND_IDX_W=6.
REQ-035 One sub-module, sha256_round_counter, SHALL provide the round_idx counter (clear, enable, terminal-count flag); everything else stays in the top level.

Verification
REQ-036 Single-block message: reset, then block_valid=1 with block_first=1 and block_last=1 at t=0.
- Expected: INIT at t=1 with first_block=1.
- Expected: round_idx 0..63 at t=2..65, update_digest at t=66, digest_valid at t=67, block_ready back to 1 at t=68.
REQ-037 Three-block message with block_valid held high:
- Expected: first_block=1 only for block 1.
- Expected: blocks accepted at cycles 0, 67 and 134.
- Expected: a single digest_valid at cycle 201.
REQ-038 block_valid=1 continuously during ROUND -> block_ready=0 and no second w_load until IDLE.
REQ-039 Reset asserted at round_idx=30 -> next cycle IDLE, all outputs 0 except block_ready=1 after release, round_idx=0.
REQ-040 block_first=0 presented right after reset -> first_block=1 is forced.
REQ-041 block_first=1 mid-message -> restart with first_block=1 and no digest_valid for the old message.
REQ-042 With SHA256_BLOCK_CNT_EN, three-block message -> block_count=3 after the last DIGEST.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round controller and its round counter.
package sha256_pkg;

   localparam int NUM_ROUNDS_DEF = 64;
   localparam int ROUND_IDX_W    = 6;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ROUND,
      DIGEST,
      DONE
   } state_t;

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Message-block handshake between a block source (master) and the round controller (slave).
interface sha256_round_ctrl_if;

   logic block_valid;
   logic block_first;
   logic block_last;
   logic block_ready;

   modport master (output block_valid, output block_first, output block_last, input block_ready);
   modport slave  (input block_valid, input block_first, input block_last, output block_ready);

endinterface

// File: rtl/sha256_round_counter.sv
// Round index counter for the SHA-256 compression loop: synchronous clear, enable, terminal flag.
module sha256_round_counter
   import sha256_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   enable,
   output logic [ROUND_IDX_W-1:0] round_idx,
   output logic                   terminal
);

   localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_ROUNDS - 1);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         round_idx <= '0;
      end else if (clear) begin
         round_idx <= '0;
      end else if (enable) begin
         round_idx <= round_idx + 1'b1;
      end
   end

   assign terminal = (round_idx == LAST_IDX);

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block/round sequencing FSM. Define SHA256_BLOCK_CNT_EN to add the
// saturating 16-bit block_count output.
module sha256_round_ctrl
   import sha256_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   sha256_round_ctrl_if.slave       blk,
   output logic                     init_round,
   output logic                     partial_rounds,
   output logic                     init_digest,
   output logic                     update_digest,
   output logic                     first_block,
   output logic [ROUND_IDX_W-1:0]   round_idx,
   output logic                     w_load,
   output logic                     busy,
   output logic                     digest_valid
`ifdef SHA256_BLOCK_CNT_EN
   ,
   output logic [15:0]              block_count
`endif
);

   state_t state_q, state_d;
   logic   last_q;
   logic   active_q;
   logic   first_q;
   logic   accept;
   logic   accept_first;
   logic   round_done;

   // Ready is withheld while reset is asserted even though the state already reads IDLE.
   assign blk.block_ready = reset_n && (state_q == IDLE);
   assign accept          = blk.block_ready && blk.block_valid;
   assign accept_first    = blk.block_first || !active_q;
   assign w_load          = accept;

   sha256_round_counter #(.NUM_ROUNDS(NUM_ROUNDS)) u_round_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    ((state_q != ROUND) || round_done),
      .enable   (state_q == ROUND),
      .round_idx(round_idx),
      .terminal (round_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b0;
         active_q <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_q   <= blk.block_last;
            first_q  <= accept_first;
            active_q <= 1'b1;
         end else if (state_q == DONE) begin
            active_q <= 1'b0;
         end
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      init_round     = 1'b0;
      init_digest    = 1'b0;
      partial_rounds = 1'b0;
      update_digest  = 1'b0;
      digest_valid   = 1'b0;
      first_block    = 1'b0;
      busy           = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = INIT;
         end
         INIT: begin
            init_round  = 1'b1;
            init_digest = 1'b1;
            first_block = first_q;
            state_d     = ROUND;
         end
         ROUND: begin
            partial_rounds = 1'b1;
            first_block    = first_q;
            if (round_done) state_d = DIGEST;
         end
         DIGEST: begin
            update_digest = 1'b1;
            first_block   = first_q;
            state_d       = last_q ? DONE : IDLE;
         end
         DONE: begin
            digest_valid = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SHA256_BLOCK_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         block_count <= '0;
      end else if (accept && accept_first) begin
         block_count <= '0;
      end else if ((state_q == DIGEST) && (block_count != 16'hFFFF)) begin
         block_count <= block_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: directed scenarios plus a random run
// against a timeline model (cycle offset since block acceptance).
module tb_sha256_round_ctrl;

   localparam int N = 64;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   sha256_round_ctrl_if blk ();

   logic       init_round;
   logic       partial_rounds;
   logic       init_digest;
   logic       update_digest;
   logic       first_block;
   logic [5:0] round_idx;
   logic       w_load;
   logic       busy;
   logic       digest_valid;
`ifdef SHA256_BLOCK_CNT_EN
   logic [15:0] block_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sha256_round_ctrl #(.NUM_ROUNDS(N)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .blk           (blk),
      .init_round    (init_round),
      .partial_rounds(partial_rounds),
      .init_digest   (init_digest),
      .update_digest (update_digest),
      .first_block   (first_block),
      .round_idx     (round_idx),
      .w_load        (w_load),
      .busy          (busy),
      .digest_valid  (digest_valid)
`ifdef SHA256_BLOCK_CNT_EN
      ,
      .block_count   (block_count)
`endif
   );

   // {ready, w_load, init_round, partial, init_digest, update, first_block, busy, digest_valid, round_idx}
   function automatic logic [14:0] obs();
      return {blk.block_ready, w_load, init_round, partial_rounds, init_digest,
              update_digest, first_block, busy, digest_valid, round_idx};
   endfunction

   // Expected outputs from the documented timeline: offset 0 = idle/accept cycle,
   // 1 = INIT, 2..N+1 = rounds, N+2 = DIGEST, N+3 = digest_valid.
   function automatic logic [14:0] expect_vec(int off, bit fb, bit valid);
      bit   in_round;
      int   idx;
      in_round = (off >= 2) && (off <= N + 1);
      idx      = in_round ? off - 2 : 0;
      return {off == 0, (off == 0) && valid, off == 1, in_round, off == 1,
              off == N + 2, fb && (off >= 1) && (off <= N + 2), off != 0,
              off == N + 3, 6'(idx)};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      blk.block_valid = 1'b0;
      blk.block_first = 1'b0;
      blk.block_last  = 1'b0;
      repeat (2) next_cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      blk.block_valid = 1'b1;
      blk.block_first = 1'b1;
      blk.block_last  = 1'b1;
      repeat (2) next_cycle();
      @(negedge clk);
      n_cmp++;
      if (obs() !== 15'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want %h", obs(), 15'd0);
      end
`ifdef SHA256_BLOCK_CNT_EN
      n_cmp++;
      if (block_count !== 16'd0) begin
         n_err++;
         $display("FAIL reset_count: got %0d want 0", block_count);
      end
`endif
      next_cycle();
      blk.block_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== expect_vec(0, 1'b0, 1'b0)) begin
         n_err++;
         $display("FAIL reset_release: got %h want %h", obs(), expect_vec(0, 1'b0, 1'b0));
      end
      next_cycle();
   endtask

   task automatic test_single_block();
      apply_reset();
      blk.block_valid = 1'b1;
      blk.block_first = 1'b1;
      blk.block_last  = 1'b1;
      for (int t = 0; t <= N + 4; t++) begin
         @(negedge clk);
         if (t == 0) begin
            n_cmp++;
            if ({blk.block_ready, w_load, busy} !== 3'b110) begin
               n_err++;
               $display("FAIL single_accept: got %b want 110", {blk.block_ready, w_load, busy});
            end
         end else if (t == 1) begin
            n_cmp++;
            if ({init_round, init_digest, first_block, partial_rounds, round_idx} !== {4'b1110, 6'd0}) begin
               n_err++;
               $display("FAIL single_init: got %b want %b",
                        {init_round, init_digest, first_block, partial_rounds, round_idx}, {4'b1110, 6'd0});
            end
         end else if (t <= N + 1) begin
            n_cmp++;
            if ({partial_rounds, init_round, update_digest, busy, blk.block_ready, w_load, round_idx} !==
                {6'b100100, 6'(t - 2)}) begin
               n_err++;
               $display("FAIL single_round t=%0d: got idx %0d partial %b ready %b want idx %0d",
                        t, round_idx, partial_rounds, blk.block_ready, t - 2);
            end
         end else if (t == N + 2) begin
            n_cmp++;
            if ({update_digest, partial_rounds, digest_valid, round_idx} !== {3'b100, 6'd0}) begin
               n_err++;
               $display("FAIL single_digest: got %b want %b",
                        {update_digest, partial_rounds, digest_valid, round_idx}, {3'b100, 6'd0});
            end
         end else if (t == N + 3) begin
            n_cmp++;
            if ({digest_valid, update_digest, first_block, busy} !== 4'b1001) begin
               n_err++;
               $display("FAIL single_done: got %b want 1001", {digest_valid, update_digest, first_block, busy});
            end
            blk.block_valid = 1'b0;
         end else begin
            n_cmp++;
            if ({blk.block_ready, busy, digest_valid} !== 3'b100) begin
               n_err++;
               $display("FAIL single_idle: got %b want 100", {blk.block_ready, busy, digest_valid});
            end
         end
         next_cycle();
         if (t == 0) blk.block_valid = 1'b0;
      end
   endtask

   // Source holds block_valid high and advances to the next block after each acceptance.
   task automatic run_message(input int nblk, input bit restart, input int cycles,
                              output int acc[$], output int fbs[$], output int dvs[$]);
      int  sent = 0;
      bit  took;
      acc = {};
      fbs = {};
      dvs = {};
      blk.block_valid = 1'b1;
      blk.block_first = 1'b1;
      blk.block_last  = (nblk == 1);
      for (int t = 0; t < cycles; t++) begin
         @(negedge clk);
         if (w_load) acc.push_back(t);
         if (init_round) fbs.push_back(int'(first_block));
         if (digest_valid) dvs.push_back(t);
         if (busy) begin
            n_cmp++;
            if ({blk.block_ready, w_load} !== 2'b00) begin
               n_err++;
               $display("FAIL busy_ready t=%0d: got %b want 00", t, {blk.block_ready, w_load});
            end
         end
         took = w_load;
         next_cycle();
         if (took) begin
            sent++;
            blk.block_first = restart;
            blk.block_last  = (sent == nblk - 1);
            if (sent == nblk) blk.block_valid = 1'b0;
         end
      end
   endtask

   task automatic test_multi_block();
      int acc[$];
      int fbs[$];
      int dvs[$];
      apply_reset();
      run_message(3, 1'b0, 3 * N + 14, acc, fbs, dvs);
      n_cmp++;
      if (acc.size() != 3 || acc[0] != 0 || acc[1] != N + 3 || acc[2] != 2 * N + 6) begin
         n_err++;
         $display("FAIL multi_accepts: got %p want 0,%0d,%0d", acc, N + 3, 2 * N + 6);
      end
      n_cmp++;
      if (fbs.size() != 3 || fbs[0] != 1 || fbs[1] != 0 || fbs[2] != 0) begin
         n_err++;
         $display("FAIL multi_first_block: got %p want 1,0,0", fbs);
      end
      n_cmp++;
      if (dvs.size() != 1 || dvs[0] != 3 * N + 9) begin
         n_err++;
         $display("FAIL multi_digest_valid: got %p want %0d", dvs, 3 * N + 9);
      end
`ifdef SHA256_BLOCK_CNT_EN
      n_cmp++;
      if (block_count !== 16'd3) begin
         n_err++;
         $display("FAIL multi_count: got %0d want 3", block_count);
      end
`endif
   endtask

   task automatic test_restart();
      int acc[$];
      int fbs[$];
      int dvs[$];
      apply_reset();
      run_message(2, 1'b1, 2 * N + 10, acc, fbs, dvs);
      n_cmp++;
      if (acc.size() != 2 || acc[1] != N + 3) begin
         n_err++;
         $display("FAIL restart_accepts: got %p want 0,%0d", acc, N + 3);
      end
      n_cmp++;
      if (fbs.size() != 2 || fbs[0] != 1 || fbs[1] != 1) begin
         n_err++;
         $display("FAIL restart_first_block: got %p want 1,1", fbs);
      end
      n_cmp++;
      if (dvs.size() != 1 || dvs[0] != 2 * N + 6) begin
         n_err++;
         $display("FAIL restart_digest_valid: got %p want %0d", dvs, 2 * N + 6);
      end
`ifdef SHA256_BLOCK_CNT_EN
      n_cmp++;
      if (block_count !== 16'd1) begin
         n_err++;
         $display("FAIL restart_count: got %0d want 1", block_count);
      end
`endif
   endtask

   task automatic test_first_forced();
      apply_reset();
      blk.block_valid = 1'b1;
      blk.block_first = 1'b0;
      blk.block_last  = 1'b1;
      next_cycle();
      blk.block_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({init_round, first_block} !== 2'b11) begin
         n_err++;
         $display("FAIL first_forced: got %b want 11", {init_round, first_block});
      end
      repeat (N + 3) next_cycle();
   endtask

   task automatic test_reset_mid_round();
      apply_reset();
      blk.block_valid = 1'b1;
      blk.block_first = 1'b1;
      blk.block_last  = 1'b1;
      next_cycle();
      blk.block_valid = 1'b0;
      repeat (31) next_cycle();
      reset_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({partial_rounds, round_idx} !== {1'b1, 6'd30}) begin
         n_err++;
         $display("FAIL mid_round_idx: got %b want %b", {partial_rounds, round_idx}, {1'b1, 6'd30});
      end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (obs() !== 15'd0) begin
         n_err++;
         $display("FAIL mid_reset_outputs: got %h want %h", obs(), 15'd0);
      end
      next_cycle();
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== expect_vec(0, 1'b0, 1'b0)) begin
         n_err++;
         $display("FAIL mid_reset_release: got %h want %h", obs(), expect_vec(0, 1'b0, 1'b0));
      end
      next_cycle();
      // The aborted message left no active flag behind, so an unmarked block starts fresh.
      blk.block_valid = 1'b1;
      blk.block_first = 1'b0;
      blk.block_last  = 1'b0;
      next_cycle();
      blk.block_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({init_round, first_block} !== 2'b11) begin
         n_err++;
         $display("FAIL mid_reset_first: got %b want 11", {init_round, first_block});
      end
      repeat (N + 3) next_cycle();
   endtask

   task automatic test_random();
      int  off    = 0;
      bit  fm     = 1'b0;
      bit  lm     = 1'b0;
      bit  active = 1'b0;
      int  cnt    = 0;
      logic [14:0] exp_v;
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         blk.block_valid = ($urandom_range(0, 1) == 1);
         blk.block_first = ($urandom_range(0, 3) == 0);
         blk.block_last  = ($urandom_range(0, 4) < 2);
         exp_v = expect_vec(off, fm, blk.block_valid);
         @(negedge clk);
         n_cmp++;
         if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL random c=%0d off=%0d: got %h want %h", c, off, obs(), exp_v);
         end
`ifdef SHA256_BLOCK_CNT_EN
         n_cmp++;
         if (block_count !== 16'(cnt)) begin
            n_err++;
            $display("FAIL random_count c=%0d: got %0d want %0d", c, block_count, cnt);
         end
`endif
         if (off == 0) begin
            if (blk.block_valid) begin
               fm     = blk.block_first || !active;
               lm     = blk.block_last;
               active = 1'b1;
               if (fm) cnt = 0;
               off = 1;
            end
         end else if (off == N + 2) begin
            if (cnt < 65535) cnt++;
            off = lm ? N + 3 : 0;
         end else if (off == N + 3) begin
            off    = 0;
            active = 1'b0;
         end else begin
            off++;
         end
         next_cycle();
      end
      blk.block_valid = 1'b0;
   endtask

   initial begin
      blk.block_valid = 1'b0;
      blk.block_first = 1'b0;
      blk.block_last  = 1'b0;
      test_reset();
      test_single_block();
      test_multi_block();
      test_restart();
      test_first_forced();
      test_reset_mid_round();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
